// File: rtl/rename_unit_p_if.sv
// Decode/issue-side bundle of the rename stage.
// slave : rename unit view (consumes decode, write-back, commit and branch
//         resolution; produces renamed instruction and active-list status).
// master: environment view (decode, write-back, retire and branch units).
interface rename_unit_p_if #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned AL_DEPTH  = 32,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned CKPT_NUM  = 4
);
  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned PW = $clog2(PHYS_REGS);
  localparam int unsigned LW = $clog2(AL_DEPTH);
  localparam int unsigned CW = $clog2(CKPT_NUM);

  logic                   dec_valid;
  logic                   dec_ready;
  logic                   dec_uses_rw;
  logic [AW-1:0]          dec_rw_addr;
  logic [AW-1:0]          dec_rs_addr;
  logic [AW-1:0]          dec_rt_addr;
  logic                   dec_is_branch;
  logic                   out_valid;
  logic [PW-1:0]          out_phys_rs;
  logic [PW-1:0]          out_phys_rt;
  logic [PW-1:0]          out_phys_rw;
  logic                   out_rs_ready;
  logic                   out_rt_ready;
  logic [LW-1:0]          out_al_id;
  logic                   out_color;
  logic [CW-1:0]          out_ckpt_id;
  logic [WB_PORTS-1:0]    wb_valid;
  logic [WB_PORTS*PW-1:0] wb_preg;
  logic                   commit_valid;
  logic [LW-1:0]          al_head_id;
  logic                   al_empty;
  logic                   br_valid;
  logic [CW-1:0]          br_ckpt_id;
  logic                   br_mispredict;

  modport slave (
    input  dec_valid, dec_uses_rw, dec_rw_addr, dec_rs_addr, dec_rt_addr, dec_is_branch,
    input  wb_valid, wb_preg, commit_valid, br_valid, br_ckpt_id, br_mispredict,
    output dec_ready, out_valid, out_phys_rs, out_phys_rt, out_phys_rw, out_rs_ready,
    output out_rt_ready, out_al_id, out_color, out_ckpt_id, al_head_id, al_empty
  );

  modport master (
    output dec_valid, dec_uses_rw, dec_rw_addr, dec_rs_addr, dec_rt_addr, dec_is_branch,
    output wb_valid, wb_preg, commit_valid, br_valid, br_ckpt_id, br_mispredict,
    input  dec_ready, out_valid, out_phys_rs, out_phys_rt, out_phys_rw, out_rs_ready,
    input  out_rt_ready, out_al_id, out_color, out_ckpt_id, al_head_id, al_empty
  );
endinterface

// File: rtl/rename_unit_p.sv
// Register-rename stage: map table, circular free list, phys ready bits,
// active-list pointers and branch checkpoints with one-cycle recovery.
// Ports: clk, rst_n (synchronous, active-low), bus (rename_unit_p_if.slave)
//   carrying the decode handshake, renamed output, write-back, commit,
//   active-list status and branch resolution.
// Optional: RENAME_WB_BYPASS_EN lets same-cycle write-backs set the
//   source-ready flags of the instruction being renamed.
module rename_unit_p #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned AL_DEPTH  = 32,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned CKPT_NUM  = 4
) (
  input logic            clk,
  input logic            rst_n,
  rename_unit_p_if.slave bus
);
  localparam int unsigned PW        = $clog2(PHYS_REGS);
  localparam int unsigned LW        = $clog2(AL_DEPTH);
  localparam int unsigned CW        = $clog2(CKPT_NUM);
  localparam int unsigned FREE_INIT = PHYS_REGS - ARCH_REGS;

  logic [PW-1:0]        map_q [ARCH_REGS];
  logic [PW-1:0]        map_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic [PW-1:0]        fl_q [PHYS_REGS];
  logic [PW-1:0]        fl_d [PHYS_REGS];
  logic [PW-1:0]        fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
  logic [PW-1:0]        al_old_q [AL_DEPTH];
  logic [PW-1:0]        al_old_d [AL_DEPTH];
  logic [LW-1:0]        al_head_q, al_head_d, al_tail_q, al_tail_d;
  logic                 al_hcol_q, al_hcol_d, al_tcol_q, al_tcol_d;
  logic                 al_empty_q, al_empty_d;
  logic [CKPT_NUM-1:0]  ckpt_vld_q, ckpt_vld_d;
  logic [CKPT_NUM-1:0]  ckpt_older_q [CKPT_NUM];
  logic [CKPT_NUM-1:0]  ckpt_older_d [CKPT_NUM];
  logic [PW-1:0]        ckpt_map_q [CKPT_NUM][ARCH_REGS];
  logic [PW-1:0]        ckpt_map_d [CKPT_NUM][ARCH_REGS];
  logic [PW-1:0]        ckpt_flh_q [CKPT_NUM];
  logic [PW-1:0]        ckpt_flh_d [CKPT_NUM];
  logic [LW-1:0]        ckpt_alt_q [CKPT_NUM];
  logic [LW-1:0]        ckpt_alt_d [CKPT_NUM];
  logic [CKPT_NUM-1:0]  ckpt_alc_q, ckpt_alc_d;

  logic          out_valid_q, out_valid_d, out_color_q, out_color_d;
  logic          out_rs_ready_q, out_rs_ready_d, out_rt_ready_q, out_rt_ready_d;
  logic [PW-1:0] out_phys_rs_q, out_phys_rs_d, out_phys_rt_q, out_phys_rt_d;
  logic [PW-1:0] out_phys_rw_q, out_phys_rw_d;
  logic [LW-1:0] out_al_id_q, out_al_id_d;
  logic [CW-1:0] out_ckpt_id_q, out_ckpt_id_d;

  logic          has_dest_c, mispredict_c, al_full_c, al_empty_c, dec_ready_c, accept_c;
  logic          ckpt_any_free_c;
  logic [CW-1:0] ckpt_free_id_c;
  logic [PW-1:0] new_preg_c, old_preg_c, src_rs_c, src_rt_c;
  logic [CW-1:0] bid_c;

  // Free-list index increment; PHYS_REGS need not be a power of two.
  function automatic logic [PW-1:0] fl_inc(input logic [PW-1:0] p);
    return (32'(p) == PHYS_REGS - 1) ? '0 : p + PW'(1);
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    map_d = map_q;           ready_d = ready_q;
    fl_d = fl_q;             fl_head_d = fl_head_q;   fl_tail_d = fl_tail_q;
    al_old_d = al_old_q;     al_head_d = al_head_q;   al_tail_d = al_tail_q;
    al_hcol_d = al_hcol_q;   al_tcol_d = al_tcol_q;
    ckpt_vld_d = ckpt_vld_q; ckpt_older_d = ckpt_older_q;
    ckpt_map_d = ckpt_map_q; ckpt_flh_d = ckpt_flh_q;
    ckpt_alt_d = ckpt_alt_q; ckpt_alc_d = ckpt_alc_q;
    out_valid_d = 1'b0;      out_color_d = 1'b0;
    out_rs_ready_d = 1'b0;   out_rt_ready_d = 1'b0;
    out_phys_rs_d = '0;      out_phys_rt_d = '0;      out_phys_rw_d = '0;
    out_al_id_d = '0;        out_ckpt_id_d = '0;
    old_preg_c = '0;
    bid_c = bus.br_ckpt_id;

    ckpt_free_id_c  = '0;
    ckpt_any_free_c = 1'b0;
    for (int i = CKPT_NUM - 1; i >= 0; i--) begin
      if (!ckpt_vld_q[i]) begin
        ckpt_free_id_c  = CW'(i);
        ckpt_any_free_c = 1'b1;
      end
    end

    has_dest_c   = bus.dec_uses_rw && (bus.dec_rw_addr != '0);
    mispredict_c = bus.br_valid && bus.br_mispredict;
    al_empty_c   = (al_head_q == al_tail_q) && (al_hcol_q == al_tcol_q);
    al_full_c    = (al_head_q == al_tail_q) && (al_hcol_q != al_tcol_q);
    // The free list never holds every preg (phys 0 is never free), so
    // head==tail always means empty.
    dec_ready_c  = !al_full_c && (!has_dest_c || (fl_head_q != fl_tail_q)) &&
                   (!bus.dec_is_branch || ckpt_any_free_c) && !mispredict_c;
    accept_c     = bus.dec_valid && dec_ready_c;
    new_preg_c   = has_dest_c ? fl_q[fl_head_q] : '0;
    src_rs_c     = map_q[bus.dec_rs_addr];
    src_rt_c     = map_q[bus.dec_rt_addr];

    // Write-back wakeup; phys 0 stays permanently ready.
    for (int k = 0; k < WB_PORTS; k++) begin
      if (bus.wb_valid[k] && (bus.wb_preg[k*PW +: PW] != '0)) begin
        ready_d[bus.wb_preg[k*PW +: PW]] = 1'b1;
      end
    end

    // Retire: recycle the displaced mapping onto the free-list tail.
    if (bus.commit_valid && !al_empty_c) begin
      old_preg_c = al_old_q[al_head_q];
      if (old_preg_c != '0) begin
        fl_d[fl_tail_q] = old_preg_c;
        fl_tail_d       = fl_inc(fl_tail_q);
      end
      al_head_d = al_head_q + LW'(1);
      if (al_head_q == LW'(AL_DEPTH - 1)) al_hcol_d = ~al_hcol_q;
    end

    if (bus.br_valid && !bus.br_mispredict) ckpt_vld_d[bid_c] = 1'b0;

    if (accept_c) begin
      out_valid_d   = 1'b1;
      out_phys_rs_d = src_rs_c;
      out_phys_rt_d = src_rt_c;
      out_phys_rw_d = new_preg_c;
      out_al_id_d   = al_tail_q;
      out_color_d   = al_tcol_q;
      out_rs_ready_d = ready_q[src_rs_c];
      out_rt_ready_d = ready_q[src_rt_c];
`ifdef RENAME_WB_BYPASS_EN
      for (int k = 0; k < WB_PORTS; k++) begin
        if (bus.wb_valid[k] && (bus.wb_preg[k*PW +: PW] == src_rs_c)) out_rs_ready_d = 1'b1;
        if (bus.wb_valid[k] && (bus.wb_preg[k*PW +: PW] == src_rt_c)) out_rt_ready_d = 1'b1;
      end
`endif
      al_old_d[al_tail_q] = has_dest_c ? map_q[bus.dec_rw_addr] : '0;
      if (has_dest_c) begin
        ready_d[new_preg_c]       = 1'b0;
        map_d[bus.dec_rw_addr]    = new_preg_c;
        fl_head_d                 = fl_inc(fl_head_q);
      end
      al_tail_d = al_tail_q + LW'(1);
      if (al_tail_q == LW'(AL_DEPTH - 1)) al_tcol_d = ~al_tcol_q;
      // Snapshot is post-rename so recovery resumes just after the branch.
      if (bus.dec_is_branch) begin
        out_ckpt_id_d                = ckpt_free_id_c;
        ckpt_older_d[ckpt_free_id_c] = ckpt_vld_d;
        ckpt_vld_d[ckpt_free_id_c]   = 1'b1;
        for (int i = 0; i < ARCH_REGS; i++) ckpt_map_d[ckpt_free_id_c][i] = map_d[i];
        ckpt_flh_d[ckpt_free_id_c]   = fl_head_d;
        ckpt_alt_d[ckpt_free_id_c]   = al_tail_d;
        ckpt_alc_d[ckpt_free_id_c]   = al_tcol_d;
      end
    end

    // Recovery: restore speculative state, drop this and all younger checkpoints.
    if (mispredict_c) begin
      for (int i = 0; i < ARCH_REGS; i++) map_d[i] = ckpt_map_q[bid_c][i];
      fl_head_d = ckpt_flh_q[bid_c];
      al_tail_d = ckpt_alt_q[bid_c];
      al_tcol_d = ckpt_alc_q[bid_c];
      for (int j = 0; j < CKPT_NUM; j++) begin
        if (ckpt_older_q[j][bid_c]) ckpt_vld_d[j] = 1'b0;
      end
      ckpt_vld_d[bid_c] = 1'b0;
    end

    // A freed slot must not be seen as older than anything later allocated.
    for (int j = 0; j < CKPT_NUM; j++) begin
      if (!ckpt_vld_d[j]) begin
        for (int i = 0; i < CKPT_NUM; i++) ckpt_older_d[i][j] = 1'b0;
      end
    end

    al_empty_d = (al_head_d == al_tail_d) && (al_hcol_d == al_tcol_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      ready_q <= '1;
      for (int i = 0; i < PHYS_REGS; i++) fl_q[i] <= (i < FREE_INIT) ? PW'(ARCH_REGS + i) : '0;
      fl_head_q <= '0;
      fl_tail_q <= PW'(FREE_INIT);
      for (int i = 0; i < AL_DEPTH; i++) al_old_q[i] <= '0;
      al_head_q <= '0;   al_tail_q <= '0;
      al_hcol_q <= 1'b0; al_tcol_q <= 1'b0;
      al_empty_q <= 1'b1;
      ckpt_vld_q <= '0;
      ckpt_alc_q <= '0;
      for (int c = 0; c < CKPT_NUM; c++) begin
        ckpt_older_q[c] <= '0;
        ckpt_flh_q[c]   <= '0;
        ckpt_alt_q[c]   <= '0;
        for (int i = 0; i < ARCH_REGS; i++) ckpt_map_q[c][i] <= '0;
      end
      out_valid_q <= 1'b0;    out_color_q <= 1'b0;
      out_rs_ready_q <= 1'b0; out_rt_ready_q <= 1'b0;
      out_phys_rs_q <= '0;    out_phys_rt_q <= '0;    out_phys_rw_q <= '0;
      out_al_id_q <= '0;      out_ckpt_id_q <= '0;
    end else begin
      map_q <= map_d;           ready_q <= ready_d;
      fl_q <= fl_d;             fl_head_q <= fl_head_d;   fl_tail_q <= fl_tail_d;
      al_old_q <= al_old_d;     al_head_q <= al_head_d;   al_tail_q <= al_tail_d;
      al_hcol_q <= al_hcol_d;   al_tcol_q <= al_tcol_d;   al_empty_q <= al_empty_d;
      ckpt_vld_q <= ckpt_vld_d; ckpt_older_q <= ckpt_older_d;
      ckpt_map_q <= ckpt_map_d; ckpt_flh_q <= ckpt_flh_d;
      ckpt_alt_q <= ckpt_alt_d; ckpt_alc_q <= ckpt_alc_d;
      out_valid_q <= out_valid_d;       out_color_q <= out_color_d;
      out_rs_ready_q <= out_rs_ready_d; out_rt_ready_q <= out_rt_ready_d;
      out_phys_rs_q <= out_phys_rs_d;   out_phys_rt_q <= out_phys_rt_d;
      out_phys_rw_q <= out_phys_rw_d;   out_al_id_q <= out_al_id_d;
      out_ckpt_id_q <= out_ckpt_id_d;
    end
  end

  assign bus.dec_ready    = dec_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_phys_rs  = out_phys_rs_q;
  assign bus.out_phys_rt  = out_phys_rt_q;
  assign bus.out_phys_rw  = out_phys_rw_q;
  assign bus.out_rs_ready = out_rs_ready_q;
  assign bus.out_rt_ready = out_rt_ready_q;
  assign bus.out_al_id    = out_al_id_q;
  assign bus.out_color    = out_color_q;
  assign bus.out_ckpt_id  = out_ckpt_id_q;
  assign bus.al_head_id   = al_head_q;
  assign bus.al_empty     = al_empty_q;
endmodule

// File: doc/rename_unit_p.md
Name: rename_unit_p

Overview:
- Parametrised register-rename stage; successor of the fixed 32-arch-register rename/regfile front end.
- Sits between decode and issue. Owns four structures:
  - map table (arch→phys)
  - circular free list
  - physical-register ready bits
  - active-list (ROB) allocation/retire pointers
- Adds what the previous generation lacks:
  - N write-back ports
  - branch checkpoints with single-cycle mispredict recovery
  - explicit valid/ready decode handshake

Parameters:
- ARCH_REGS, 32, architectural registers; reg 0 hardwired to phys 0.
- PHYS_REGS, 64, physical registers (> ARCH_REGS).
- AL_DEPTH, 32, active-list entries (power of 2).
- WB_PORTS, 2, write-back ports marking phys regs ready.
- CKPT_NUM, 4, branch checkpoints.
- Derived widths: AW=$clog2(ARCH_REGS), PW=$clog2(PHYS_REGS), LW=$clog2(AL_DEPTH), CW=$clog2(CKPT_NUM).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- dec_valid  in  1  decoded instruction present
- dec_ready  out  1  rename accepts this cycle
- dec_uses_rw  in  1  has destination
- dec_rw_addr  in  AW  dest arch reg
- dec_rs_addr  in  AW  source arch reg
- dec_rt_addr  in  AW  source arch reg
- dec_is_branch  in  1  conditional branch; needs checkpoint
- out_valid  out  1  renamed instruction valid (registered)
- out_phys_rs  out  PW  renamed source
- out_phys_rt  out  PW  renamed source
- out_phys_rw  out  PW  allocated dest (0 if none)
- out_rs_ready  out  1  source ready at rename
- out_rt_ready  out  1  source ready at rename
- out_al_id  out  LW  active-list slot
- out_color  out  1  wrap colour of slot
- out_ckpt_id  out  CW  checkpoint taken (valid if branch)
- wb_valid  in  WB_PORTS  write-back strobes
- wb_preg  in  WB_PORTS*PW  write-back phys regs
- commit_valid  in  1  retire active-list head
- al_head_id  out  LW  oldest entry
- al_empty  out  1  no live entries
- br_valid  in  1  branch resolved
- br_ckpt_id  in  CW  resolved checkpoint
- br_mispredict  in  1  restore to checkpoint

Behaviour:
- Reset (rst_n=0 at clk edge):
  - map[i]=i; ready all 1.
  - free list holds ARCH_REGS..PHYS_REGS-1; free_count=PHYS_REGS-ARCH_REGS.
  - AL head=tail=0, colours 0; all checkpoints free.
  - All outputs 0 except al_empty=1 and dec_ready per stall equation.
  - Reset mid-operation discards everything; no partial state survives.
- Destination rule: dest exists iff dec_uses_rw && dec_rw_addr!=0. Arch reg 0 never renamed; phys 0 always ready.
- dec_ready is combinational. It is 1 only when all hold:
  - AL not full
  - free_count>0 if dest
  - a checkpoint is free if dec_is_branch
  - no br_valid&&br_mispredict this cycle
- Accept = dec_valid&&dec_ready. On accept:
  - Sources read from the pre-update map.
  - Pop free-list head → new preg. Clear its ready bit. Map[rw]=new preg.
  - Store old mapping in AL[tail]. Tail++; colour toggles when tail wraps to 0.
  - Outputs registered: 1-cycle latency. out_valid=0 on any non-accept cycle.
- Same-instruction rs==rw: source gets the OLD mapping.
- Checkpoint: on accepted branch, snapshot post-rename map, free-list head and AL tail into the lowest free slot; report its id.
- Write-back: each wb_valid[k] sets ready[wb_preg[k]] next cycle. Multiple ports may hit distinct pregs the same cycle. wb to preg 0 is ignored.
- Commit: commit_valid with AL non-empty pops head and pushes the stored old preg onto the free-list tail (skip if 0). commit_valid on empty AL is ignored.
- Resolve:
  - br_valid && !br_mispredict frees that checkpoint.
  - br_valid && br_mispredict restores map, free head and AL tail (and tail colour) from the checkpoint in one cycle.
  - It then frees that checkpoint and every checkpoint allocated after it (age tracked by allocation order).
  - The same cycle's rename is blocked.
  - Ready bits are not restored; squashed pregs return via the restored head.
- Simultaneous events:
  - Commit-free and alloc in one cycle both proceed.
  - free_count updates by +1−1 = 0.
  - An alloc when free_count==0 is impossible, because dec_ready=0.
  - Mispredict beats alloc. Commit still applies during mispredict.

Optional Feature:
- Macro: RENAME_WB_BYPASS_EN.
- Defined: out_rs_ready/out_rt_ready also assert when the looked-up preg matches any same-cycle wb_preg with wb_valid.
- Undefined: ready reflects only the stored ready bits. A same-cycle write-back is visible one cycle later, and issue must wake up via the WB bus.

Test Plan:
- Reset, then rename rw=5 → out_phys_rw=32, map[5]=32, out_al_id=0; next rename of rs=5 → out_phys_rs=32, out_rs_ready=0.
- Rename 32 dests with no commit → dec_ready=0 at AL full (AL_DEPTH=32) and free_count=0; one commit_valid → dec_ready=1 next cycle, freed preg reused after list wrap.
- Branch (ckpt 0) then rename rw=3→33 and rw=4→34; br_mispredict ckpt 0 → map[3],map[4] restored, next alloc returns 33, tail back to branch+1.
- wb_valid={1,1}, wb_preg={32,33} → both ready next cycle; with RENAME_WB_BYPASS_EN, same-cycle rename of rs=5 (→32) reports out_rs_ready=1.
- dec_rw_addr=0 with uses_rw=1 → out_phys_rw=0, free_count unchanged; 4 outstanding branches → 5th branch stalls until br_valid frees one.
- Assert rst_n=0 while AL holds 10 entries and 2 checkpoints → next cycle identity map, al_empty=1, out_valid=0.
